rr_slot_arbiter: RTL and testbench

Round-robin arbiter that shares one resource among NUM_REQ requesters and issues a registered one-hot grant. Search priority comes from an internal one-hot rotating pointer (0001 → 0010 → 0100 → 1000 → 0001). A grant is held for as long as its owner keeps requesting. The block sits between the requesting units and the shared datapath; the datapath enable is taken directly from `grant`.

---
 rtl/rr_slot_arbiter.sv | 129 ++++++++++++
 tb/tb_rr_slot_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/rr_slot_arbiter.sv
// Round-robin arbiter: registered one-hot grant held while the owner requests,
// rotating one-hot search pointer. Optional hold-time preemption via RR_TIMEOUT_EN.
module rr_slot_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t             state;
    logic [NUM_REQ-1:0] ptr;

    int unsigned        ptr_pos;
    int unsigned        pos;
    logic [NUM_REQ-1:0] cand;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic [NUM_REQ-1:0] win_ptr;
    logic               owner_req;
    logic               timeout_hit;
    logic               take;
    logic               drop;

    generate
        if (NUM_REQ < 2 || MAX_HOLD < 2) begin : g_param_check
            $error("rr_slot_arbiter: NUM_REQ and MAX_HOLD must both be >= 2");
        end
    endgenerate

`ifdef RR_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);
    logic [CNT_W-1:0] hold_cnt;

    assign timeout_hit = (hold_cnt == CNT_W'(MAX_HOLD - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Winner search from the pointer position upward with wrap; the current
    // owner is masked so a preemption always lands on someone else.
    always_comb begin
        ptr_pos   = 0;
        pos       = 0;
        cand      = req & ~grant;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ptr[i]) ptr_pos = i;
        end
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            pos = ptr_pos + off;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            if (!win_found && cand[IDX_W'(pos)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(pos);
            end
        end
        win_oh  = NUM_REQ'(1) << win_idx;
        win_ptr = {win_oh[NUM_REQ-2:0], win_oh[NUM_REQ-1]};
    end

    // Next-transition decision: new grant (take) or return to idle (drop).
    always_comb begin
        owner_req = |(req & grant);
        take      = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE:  take = win_found;
            OWNED: begin
                if (!owner_req) begin
                    take = win_found;
                    drop = !win_found;
                end else if (timeout_hit && win_found) begin
                    take = 1'b1;
                end
            end
            default: drop = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            ptr       <= NUM_REQ'(1);
`ifdef RR_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
        end else if (take) begin
            state     <= OWNED;
            grant     <= win_oh;
            grant_idx <= win_idx;
            busy      <= 1'b1;
            ptr       <= win_ptr;
`ifdef RR_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
        end else if (drop) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
`ifdef RR_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
        end else if (state == OWNED) begin
`ifdef RR_TIMEOUT_EN
            // Lone owner at the limit keeps the grant with a fresh window.
            hold_cnt  <= timeout_hit ? '0 : hold_cnt + CNT_W'(1);
`endif
        end
    end

endmodule

// File: tb/tb_rr_slot_arbiter.sv
// Directed self-checking bench for rr_slot_arbiter (NUM_REQ=4, MAX_HOLD=8).
module tb_rr_slot_arbiter;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req   = 4'b0000;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       busy;

    int checks = 0;
    int errors = 0;

    rr_slot_arbiter #(.NUM_REQ(4), .MAX_HOLD(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] idx, input logic b);
        check({tag, ".grant"},     32'(grant),     32'(g));
        check({tag, ".grant_idx"}, 32'(grant_idx), 32'(idx));
        check({tag, ".busy"},      32'(busy),      32'(b));
    endtask

    // Apply req at the falling edge, sample 1 time unit after the next rising edge.
    task automatic step(input logic [3:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_g;
        logic [1:0] exp_i;

        #1 reset = 1'b1;
        #2;
        expect_out("reset_init", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        step(4'b0100);
        expect_out("single_req", 4'b0100, 2'd2, 1'b1);
        step(4'b0000);
        expect_out("single_release", 4'b0000, 2'd0, 1'b0);

        // ptr now 1000: search wraps from bit 3 to bit 0
        step(4'b0011);
        expect_out("wrap_search", 4'b0001, 2'd0, 1'b1);
        for (int n = 0; n < 4; n++) begin
            step(4'b0011);
            expect_out("hold_short", 4'b0001, 2'd0, 1'b1);
        end
        step(4'b0000);
        expect_out("idle_again", 4'b0000, 2'd0, 1'b0);

        // ptr now 0010
        step(4'b1111);
        expect_out("all_req_ptr1", 4'b0010, 2'd1, 1'b1);

        // Async reset mid-cycle while a grant is held
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        expect_out("async_reset", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        expect_out("post_reset_first", 4'b0001, 2'd0, 1'b1);

        // Full round robin: each owner releases after one cycle, then re-requests
        step(4'b1110);
        expect_out("rr_1", 4'b0010, 2'd1, 1'b1);
        step(4'b1101);
        expect_out("rr_2", 4'b0100, 2'd2, 1'b1);
        step(4'b1011);
        expect_out("rr_3", 4'b1000, 2'd3, 1'b1);
        step(4'b0111);
        expect_out("rr_wrap", 4'b0001, 2'd0, 1'b1);

        // Priority after wrap: owner 3 releases, then req=1001 favours requester 0
        step(4'b0000);
        expect_out("rr_idle", 4'b0000, 2'd0, 1'b0);
        step(4'b1000);
        expect_out("owner3", 4'b1000, 2'd3, 1'b1);
        step(4'b0000);
        expect_out("owner3_release", 4'b0000, 2'd0, 1'b0);
        step(4'b1001);
        expect_out("prio_after_wrap", 4'b0001, 2'd0, 1'b1);

        // Non-owner dropping its request has no effect
        step(4'b0001);
        expect_out("nonowner_drop", 4'b0001, 2'd0, 1'b1);
        step(4'b0000);
        expect_out("release_to_idle", 4'b0000, 2'd0, 1'b0);

        // ptr now 0010: constant req=0011 starts with requester 1
`ifdef RR_TIMEOUT_EN
        for (int n = 0; n < 24; n++) begin
            step(4'b0011);
            exp_g = ((n / 8) % 2 == 0) ? 4'b0010 : 4'b0001;
            exp_i = ((n / 8) % 2 == 0) ? 2'd1 : 2'd0;
            expect_out($sformatf("timeout_alt_%0d", n), exp_g, exp_i, 1'b1);
        end
        step(4'b0000);
        expect_out("timeout_idle", 4'b0000, 2'd0, 1'b0);
        for (int n = 0; n < 20; n++) begin
            step(4'b0100);
            expect_out($sformatf("lone_owner_%0d", n), 4'b0100, 2'd2, 1'b1);
        end
`else
        exp_g = 4'b0010;
        exp_i = 2'd1;
        for (int n = 0; n < 12; n++) begin
            step(4'b0011);
            expect_out($sformatf("no_timeout_hold_%0d", n), exp_g, exp_i, 1'b1);
        end
        step(4'b0001);
        expect_out("handover_after_hold", 4'b0001, 2'd0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
